trivium_ctrl: RTL

Word-level session controller for the bit-serial Trivium core. It accepts an 80-bit key, an 80-bit IV and 32-bit plaintext words from a host. It serialises key and IV into the core, runs the warm-up rounds, streams each word through the core LSB first and reassembles the 32-bit ciphertext. It sits between the host bus and the core's dat/init/end serial port.

---
 rtl/trivium_pkg.sv | 24 ++
 rtl/trivium_ser_des.sv | 41 ++++
 rtl/trivium_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/trivium_pkg.sv
// rtl/trivium_pkg.sv - shared widths, state codes and helpers for the Trivium session controller
package trivium_pkg;

  localparam int KEY_W_DEF         = 80;
  localparam int IV_W_DEF          = 80;
  localparam int WORD_W_DEF        = 32;
  localparam int WARMUP_CYCLES_DEF = 1152;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_KEY  = 3'd1;
  localparam logic [2:0] ST_LOAD_IV   = 3'd2;
  localparam logic [2:0] ST_WARMUP    = 3'd3;
  localparam logic [2:0] ST_WAIT_WORD = 3'd4;
  localparam logic [2:0] ST_SHIFT     = 3'd5;
  localparam logic [2:0] ST_CAPTURE   = 3'd6;
  localparam logic [2:0] ST_OUT_WAIT  = 3'd7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/trivium_ser_des.sv
// rtl/trivium_ser_des.sv - plaintext PISO and ciphertext SIPO, both LSB first
module trivium_ser_des
  import trivium_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] par_i,
  input  logic              shift_i,
  input  logic              capture_i,
  input  logic              ser_i,
  output logic              ser_o,
  output logic [WORD_W-1:0] par_o
);

  logic [WORD_W-1:0] piso;
  logic [WORD_W-1:0] sipo;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      piso <= '0;
      sipo <= '0;
    end else begin
      if (load_i) begin
        piso <= par_i;
      end else if (shift_i) begin
        piso <= {1'b0, piso[WORD_W-1:1]};
      end
      // Bits enter at the top; after WORD_W captures the first one sits in bit 0.
      if (capture_i) begin
        sipo <= {ser_i, sipo[WORD_W-1:1]};
      end
    end
  end

  assign ser_o = piso[0];
  assign par_o = sipo;

endmodule

// File: rtl/trivium_ctrl.sv
// rtl/trivium_ctrl.sv - word-level session controller driving the bit-serial Trivium core
module trivium_ctrl
  import trivium_pkg::*;
#(
  parameter int KEY_W         = KEY_W_DEF,
  parameter int IV_W          = IV_W_DEF,
  parameter int WORD_W        = WORD_W_DEF,
  parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              start_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [IV_W-1:0]   iv_i,
  input  logic              stop_i,
  input  logic              in_valid_i,
  input  logic [WORD_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              core_dat_o,
  output logic              core_init_o,
  output logic              core_en_o,
  output logic              core_end_o,
  input  logic              core_dat_i
);

  localparam int CNT_W  = $clog2(max3(KEY_W, IV_W, WORD_W));
  localparam int WARM_W = $clog2(WARMUP_CYCLES);

  localparam logic [CNT_W-1:0]  KEY_LAST  = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0]  IV_LAST   = CNT_W'(IV_W - 1);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(WORD_W - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WARM_W-1:0] warm_cnt;
  logic [KEY_W-1:0]  key_r;
  logic [IV_W-1:0]   iv_r;

  logic word_load;
  logic word_shift;
  logic word_capture;
  logic word_bit;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      warm_cnt <= '0;
      key_r    <= '0;
      iv_r     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            key_r <= key_i;
            iv_r  <= iv_i;
            state <= ST_LOAD_KEY;
          end
        end
        ST_LOAD_KEY: begin
          if (bit_cnt == KEY_LAST) begin
            bit_cnt <= '0;
            state   <= ST_LOAD_IV;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_LOAD_IV: begin
          if (bit_cnt == IV_LAST) begin
            bit_cnt <= '0;
            state   <= ST_WARMUP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            warm_cnt <= '0;
            state    <= ST_WAIT_WORD;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        ST_WAIT_WORD: begin
          // A pending word takes priority over a stop request.
          if (in_valid_i) begin
            state <= ST_SHIFT;
          end else if (stop_i) begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == WORD_LAST) begin
            bit_cnt <= '0;
            state   <= ST_CAPTURE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          state <= ST_OUT_WAIT;
        end
        ST_OUT_WAIT: begin
          if (out_ready_i) begin
            state <= ST_WAIT_WORD;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Core output lags core_en_o by one cycle, so SHIFT k=0 has nothing to capture yet.
  assign word_load    = (state == ST_WAIT_WORD) && in_valid_i;
  assign word_shift   = (state == ST_SHIFT);
  assign word_capture = ((state == ST_SHIFT) && (bit_cnt != '0)) || (state == ST_CAPTURE);

  trivium_ser_des #(
    .WORD_W (WORD_W)
  ) u_ser_des (
    .clk_i     (clk_i),
    .n_rst_i   (n_rst_i),
    .load_i    (word_load),
    .par_i     (in_data_i),
    .shift_i   (word_shift),
    .capture_i (word_capture),
    .ser_i     (core_dat_i),
    .ser_o     (word_bit),
    .par_o     (out_data_o)
  );

  always_comb begin
    core_dat_o = 1'b0;
    case (state)
      ST_LOAD_KEY: core_dat_o = key_r[bit_cnt];
      ST_LOAD_IV:  core_dat_o = iv_r[bit_cnt];
      ST_SHIFT:    core_dat_o = word_bit;
      default:     core_dat_o = 1'b0;
    endcase
  end

  assign in_ready_o  = (state == ST_WAIT_WORD);
  assign out_valid_o = (state == ST_OUT_WAIT);
  assign busy_o      = (state != ST_IDLE);
  assign core_init_o = (state == ST_LOAD_KEY) || (state == ST_LOAD_IV);
  assign core_en_o   = (state == ST_WARMUP) || (state == ST_SHIFT);
  assign core_end_o  = (state == ST_WAIT_WORD) && stop_i && !in_valid_i;

endmodule
